// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, instruction length and the
// width/reset defaults common to the fetch unit and the instruction register.
package cpu_pkg;

  localparam int          CPU_D_WIDTH  = 32;
  localparam int          CPU_A_WIDTH  = 32;
  localparam int          ILEN_BYTES   = 4;
  localparam logic [31:0] CPU_RESET_PC = 32'h0000_0000;

  typedef enum logic [2:0] {
    FS_IDLE  = 3'd0,
    FS_FETCH = 3'd1,
    FS_FLUSH = 3'd2,
    FS_HOLD  = 3'd3,
    FS_HALT  = 3'd4
  } fetch_state_e;

  // A fetch address is legal only on a word boundary.
  function automatic logic is_word_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/ifetch_pc_reg.sv
// Program counter register with load and sequential increment; load wins.
module pc_reg
  import cpu_pkg::*;
#(
  parameter int                 A_WIDTH  = CPU_A_WIDTH,
  parameter logic [A_WIDTH-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [A_WIDTH-1:0] load_pc,
  input  logic               inc,
  output logic [A_WIDTH-1:0] pc
);

  logic [A_WIDTH-1:0] pc_d;
  logic [A_WIDTH-1:0] pc_q;

  // Next PC; the increment wraps naturally modulo 2^A_WIDTH.
  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_pc;
    end else if (inc) begin
      pc_d = pc_q + A_WIDTH'(ILEN_BYTES);
    end else begin
      pc_d = pc_q;
    end
  end

  // PC state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch unit: issues word reads over req/ack, buffers the word for
// the IR and handles redirects, including those racing an outstanding request.
module ifetch
  import cpu_pkg::*;
#(
  parameter int                 D_WIDTH  = CPU_D_WIDTH,
  parameter int                 A_WIDTH  = CPU_A_WIDTH,
  parameter logic [A_WIDTH-1:0] RESET_PC = A_WIDTH'(CPU_RESET_PC)
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [A_WIDTH-1:0] imem_addr,
  input  logic               imem_ack,
  input  logic [D_WIDTH-1:0] imem_rdata,
  input  logic               ir_ready,
  input  logic               redirect,
  input  logic [A_WIDTH-1:0] redirect_pc,
  output logic [D_WIDTH-1:0] isu,
  output logic               isu_valid,
  output logic               isu_en,
  output logic [A_WIDTH-1:0] pc_out,
  output logic               fault
);

  fetch_state_e       state_d, state_q;
  logic [A_WIDTH-1:0] flush_addr_d, flush_addr_q;
  logic [D_WIDTH-1:0] isu_d, isu_q;
  logic [A_WIDTH-1:0] pc_out_d, pc_out_q;
  logic [A_WIDTH-1:0] pc_s;
  logic               pc_load_s;
  logic               pc_inc_s;
  logic               aligned_s;

  pc_reg #(
    .A_WIDTH (A_WIDTH),
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk    (clk),
    .rst    (rst),
    .load   (pc_load_s),
    .load_pc(redirect_pc),
    .inc    (pc_inc_s),
    .pc     (pc_s)
  );

  assign aligned_s = is_word_aligned(pc_s[1:0]);

  // Fetch FSM next state; redirect outranks both ack and ir_ready.
  always_comb begin
    state_d      = state_q;
    flush_addr_d = flush_addr_q;
    isu_d        = isu_q;
    pc_out_d     = pc_out_q;
    pc_load_s    = 1'b0;
    pc_inc_s     = 1'b0;
    case (state_q)
      FS_IDLE: begin
        pc_load_s = redirect;
        state_d   = FS_FETCH;
      end
      FS_FETCH: begin
        if (redirect) begin
          pc_load_s = 1'b1;
          // Only a request still in flight needs draining through FLUSH.
          if (imem_ack || !aligned_s) begin
            state_d = FS_FETCH;
          end else begin
            flush_addr_d = pc_s;
            state_d      = FS_FLUSH;
          end
        end else if (!aligned_s) begin
          state_d = FS_HALT;
        end else if (imem_ack) begin
          isu_d    = imem_rdata;
          pc_out_d = pc_s;
          state_d  = FS_HOLD;
        end else begin
          state_d = FS_FETCH;
        end
      end
      FS_FLUSH: begin
        pc_load_s = redirect;
        if (imem_ack) begin
          state_d = FS_FETCH;
        end else begin
          state_d = FS_FLUSH;
        end
      end
      FS_HOLD: begin
        if (redirect) begin
          pc_load_s = 1'b1;
          state_d   = FS_FETCH;
        end else if (ir_ready) begin
          pc_inc_s = 1'b1;
          state_d  = FS_FETCH;
        end else begin
          state_d = FS_HOLD;
        end
      end
      FS_HALT: begin
        pc_load_s = redirect;
        if (redirect && is_word_aligned(redirect_pc[1:0])) begin
          state_d = FS_FETCH;
        end else begin
          state_d = FS_HALT;
        end
      end
      default: begin
        state_d = FS_IDLE;
      end
    endcase
  end

  // State, flush address and IR-side buffer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FS_IDLE;
      flush_addr_q <= RESET_PC;
      isu_q        <= '0;
      pc_out_q     <= RESET_PC;
    end else begin
      state_q      <= state_d;
      flush_addr_q <= flush_addr_d;
      isu_q        <= isu_d;
      pc_out_q     <= pc_out_d;
    end
  end

  assign imem_req  = ((state_q == FS_FETCH) && aligned_s) || (state_q == FS_FLUSH);
  assign imem_addr = (state_q == FS_FLUSH) ? flush_addr_q : pc_s;
  assign isu_valid = (state_q == FS_HOLD);
  assign isu_en    = isu_valid & ir_ready & ~redirect;
  assign fault     = (state_q == FS_HALT);
  assign isu       = isu_q;
  assign pc_out    = pc_out_q;

endmodule

// File: tb/tb_ifetch.sv
// Directed self-checking bench for ifetch: hand-computed expectations checked
// with immediate assertions one cycle step at a time.
module tb_ifetch;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        ir_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] isu;
  logic        isu_valid;
  logic        isu_en;
  logic [31:0] pc_out;
  logic        fault;

  int n_checks = 0;
  int n_fails  = 0;

  ifetch #(.D_WIDTH(32), .A_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .ir_ready   (ir_ready),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .isu        (isu),
    .isu_valid  (isu_valid),
    .isu_en     (isu_en),
    .pc_out     (pc_out),
    .fault      (fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 2 time units after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".req"},   {31'd0, imem_req},  32'h0);
    chk({tag, ".addr"},  imem_addr,          32'h0);
    chk({tag, ".isu"},   isu,                32'h0);
    chk({tag, ".valid"}, {31'd0, isu_valid}, 32'h0);
    chk({tag, ".en"},    {31'd0, isu_en},    32'h0);
    chk({tag, ".pcout"}, pc_out,             32'h0);
    chk({tag, ".fault"}, {31'd0, fault},     32'h0);
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; ir_ready = 1'b1;
    redirect = 1'b0; redirect_pc = 32'h0;
    tick(); tick();
    #1; chk_reset_outputs("rst0");
    rst = 1'b0;
    tick();                                   // IDLE -> FETCH

    // Zero-wait fetch at 0 with ir_ready high
    imem_ack = 1'b1; imem_rdata = 32'h0050_0093; #1;
    chk("t1.req", {31'd0, imem_req}, 32'h1);
    chk("t1.addr", imem_addr, 32'h0);
    tick();
    imem_ack = 1'b0; #1;
    chk("t1.isu", isu, 32'h0050_0093);
    chk("t1.en", {31'd0, isu_en}, 32'h1);
    chk("t1.pcout", pc_out, 32'h0);
    tick();

    // Two wait states at 4
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t2.req_wait", {31'd0, imem_req}, 32'h1);
      chk("t2.addr_wait", imem_addr, 32'h4);
      chk("t2.valid_wait", {31'd0, isu_valid}, 32'h0);
      tick();
    end
    imem_ack = 1'b1; imem_rdata = 32'hCAFE_0001; #1;
    chk("t2.req_ack", {31'd0, imem_req}, 32'h1);
    chk("t2.addr_ack", imem_addr, 32'h4);
    chk("t2.valid_ack", {31'd0, isu_valid}, 32'h0);
    tick();

    // HOLD with ir_ready low for 3 cycles
    imem_ack = 1'b0; ir_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3.valid", {31'd0, isu_valid}, 32'h1);
      chk("t3.en_low", {31'd0, isu_en}, 32'h0);
      chk("t3.isu", isu, 32'hCAFE_0001);
      chk("t3.pcout", pc_out, 32'h4);
      tick();
    end
    ir_ready = 1'b1; #1;
    chk("t3.en_rise", {31'd0, isu_en}, 32'h1);
    tick();

    // Redirect to 0x100 while the request at 8 is outstanding
    redirect = 1'b1; redirect_pc = 32'h100; #1;
    chk("t4.req", {31'd0, imem_req}, 32'h1);
    chk("t4.addr", imem_addr, 32'h8);
    tick();
    redirect = 1'b0; #1;
    chk("t4.flush_req", {31'd0, imem_req}, 32'h1);
    chk("t4.flush_addr", imem_addr, 32'h8);
    tick();
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
    chk("t4.flush_addr_ack", imem_addr, 32'h8);
    tick();
    imem_ack = 1'b0; #1;
    chk("t4.dropped_valid", {31'd0, isu_valid}, 32'h0);
    chk("t4.dropped_en", {31'd0, isu_en}, 32'h0);
    chk("t4.new_req", {31'd0, imem_req}, 32'h1);
    chk("t4.new_addr", imem_addr, 32'h100);
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    tick();

    // Word from 0x100 in HOLD, discarded by a misaligned redirect
    imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h102; #1;
    chk("t5.isu", isu, 32'h1234_5678);
    chk("t5.pcout", pc_out, 32'h100);
    chk("t5.en_redirect", {31'd0, isu_en}, 32'h0);
    tick();
    redirect = 1'b0; #1;
    chk("t5.mis_req", {31'd0, imem_req}, 32'h0);
    tick();
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t5.halt_fault", {31'd0, fault}, 32'h1);
      chk("t5.halt_req", {31'd0, imem_req}, 32'h0);
      tick();
    end
    redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect = 1'b0; #1;
    chk("t5.clr_fault", {31'd0, fault}, 32'h0);
    chk("t5.req_200", {31'd0, imem_req}, 32'h1);
    chk("t5.addr_200", imem_addr, 32'h200);

    // Redirect coinciding with ack drops the data; then wrap past 0xFFFFFFFC
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; imem_ack = 1'b1; imem_rdata = 32'h0BAD_0BAD;
    tick();
    redirect = 1'b0; imem_ack = 1'b0; #1;
    chk("t6.drop_valid", {31'd0, isu_valid}, 32'h0);
    chk("t6.addr_top", imem_addr, 32'hFFFF_FFFC);
    imem_ack = 1'b1; imem_rdata = 32'h0000_0013;
    tick();
    imem_ack = 1'b0; #1;
    chk("t6.en_top", {31'd0, isu_en}, 32'h1);
    chk("t6.pcout_top", pc_out, 32'hFFFF_FFFC);
    tick();
    #1;
    chk("t6.wrap_addr", imem_addr, 32'h0);
    chk("t6.wrap_req", {31'd0, imem_req}, 32'h1);
    chk("t6.wrap_fault", {31'd0, fault}, 32'h0);

    // Reset with a request outstanding drops imem_req immediately
    rst = 1'b1; #1;
    chk_reset_outputs("t7.rst_fetch");
    rst = 1'b0;
    tick(); tick();
    imem_ack = 1'b1; imem_rdata = 32'h7777_7777;
    tick();
    imem_ack = 1'b0; ir_ready = 1'b0; #1;
    chk("t7.hold_valid", {31'd0, isu_valid}, 32'h1);
    chk("t7.hold_isu", isu, 32'h7777_7777);
    rst = 1'b1; #1;
    chk_reset_outputs("t7.rst_hold");
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
